// File: rtl/sqrt_pkg.sv
// Shared definitions for the vector-magnitude path (sqrt_sumsq_feeder + sqrt_calculator).
// Holds the feeder FSM state encoding and the operand widths both blocks agree on.
package sqrt_pkg;

  // sqrt_calculator operand width (signed) and root width
  localparam int SQRT_IN_W  = 16;
  localparam int SQRT_OUT_W = 8;

  // Largest non-negative value sqrt_calculator accepts without flagging an error
  localparam logic [SQRT_IN_W-1:0] SAT_MAX = {1'b0, {(SQRT_IN_W-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE,
    SQX,
    SQY,
    ISSUE,
    WAIT
  } state_t;

endpackage

// File: rtl/sumsq_sat_add.sv
// Accumulate one square into the running sum and clamp the result to the
// largest non-negative W-bit signed value (SAT_MAX at the standard width).
module sumsq_sat_add #(
  parameter int W = 16
) (
  input  logic [W:0]   i_acc,
  input  logic [W-1:0] i_sq,
  output logic [W:0]   o_sum,
  output logic [W-1:0] o_clamped,
  output logic         o_sat
);

  // Clamp limit carried at W+1 bits so the comparison sees the carry bit
  localparam logic [W:0] LIMIT = {2'b00, {(W-1){1'b1}}};

  logic [W:0] w_sum;

  assign w_sum     = i_acc + {1'b0, i_sq};
  assign o_sum     = w_sum;
  assign o_sat     = (w_sum > LIMIT);
  assign o_clamped = o_sat ? LIMIT[W-1:0] : w_sum[W-1:0];

endmodule

// File: rtl/sqrt_sumsq_feeder.sv
// Front end of the vector-magnitude path: accepts a signed (x, y) pair, forms
// x*x + y*y on a single time-shared squarer, clamps it to the non-negative
// signed range and hands it to sqrt_calculator, holding off new pairs until
// the root is done.
// Optional build macro: SQRT_TIMEOUT_EN adds a WAIT watchdog and the timeout port.
module sqrt_sumsq_feeder
  import sqrt_pkg::*;
#(
  parameter int IN_W        = 8,
  parameter int OUT_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_x,
  input  logic signed [IN_W-1:0] in_y,
  output logic                   sq_start,
  output logic [OUT_W-1:0]       sq_in,
  input  logic                   sq_done,
  output logic                   busy,
  output logic                   sat
`ifdef SQRT_TIMEOUT_EN
  ,
  output logic                   timeout
`endif
);

  // A square of an IN_W operand must fit the OUT_W operand exactly
  generate
    if (OUT_W != 2 * IN_W) begin : g_bad_width
      $error("sqrt_sumsq_feeder: OUT_W must equal 2*IN_W");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("sqrt_sumsq_feeder: TIMEOUT_CYC must be at least 1");
    end
  endgenerate

  state_t                 r_state;
  state_t                 w_state_next;
  logic signed [IN_W-1:0] r_x;
  logic signed [IN_W-1:0] r_y;
  logic [OUT_W:0]         r_acc;
  logic [OUT_W-1:0]       r_sq_in;
  logic                   r_sat;

  logic                     w_accept;
  logic                     w_sq_start;
  logic                     w_timeout_hit;
  logic signed [IN_W-1:0]   w_sq_op;
  logic signed [2*IN_W-1:0] w_sq_prod;
  logic [OUT_W-1:0]         w_sq;
  logic [OUT_W:0]           w_sum;
  logic [OUT_W-1:0]         w_clamped;
  logic                     w_sat;

  assign w_accept = in_valid && (r_state == IDLE);

  // Single squarer: y is squared in SQY, x otherwise. The product of a signed
  // value with itself is never negative, so it is reused as an unsigned word.
  assign w_sq_op   = (r_state == SQY) ? r_y : r_x;
  assign w_sq_prod = w_sq_op * w_sq_op;
  assign w_sq      = w_sq_prod;

  sumsq_sat_add #(
    .W (OUT_W)
  ) u_sat_add (
    .i_acc     (r_acc),
    .i_sq      (w_sq),
    .o_sum     (w_sum),
    .o_clamped (w_clamped),
    .o_sat     (w_sat)
  );

`ifdef SQRT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;
  logic             w_cnt_expired;

  assign w_cnt_expired = (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout       = r_timeout;

  // Watchdog: count cycles spent in WAIT, restart from zero on every entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout_hit;
      if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and the start strobe; sq_done only matters in WAIT
  always_comb begin
    w_state_next  = r_state;
    w_sq_start    = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = SQX;
        end
      end
      SQX:   w_state_next = SQY;
      SQY:   w_state_next = ISSUE;
      ISSUE: begin
        w_sq_start   = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (sq_done) begin
          w_state_next = IDLE;
`ifdef SQRT_TIMEOUT_EN
        end else if (w_cnt_expired) begin
          w_timeout_hit = 1'b1;
          w_state_next  = IDLE;
`endif
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: capture the pair, build the sum of squares, latch the operand
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      r_sq_in <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x   <= in_x;
            r_y   <= in_y;
            r_sat <= 1'b0;
          end
        end
        SQX: r_acc <= {1'b0, w_sq};
        SQY: begin
          r_acc   <= w_sum;
          r_sq_in <= w_clamped;
          r_sat   <= w_sat;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign sq_start = w_sq_start;
  assign sq_in    = r_sq_in;
  assign sat      = r_sat;

endmodule

// File: tb/tb_sqrt_sumsq_feeder.sv
// Directed self-checking bench for sqrt_sumsq_feeder (default build).
module tb_sqrt_sumsq_feeder;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_x;
  logic signed [7:0] in_y;
  logic              sq_start;
  logic [15:0]       sq_in;
  logic              sq_done;
  logic              busy;
  logic              sat;
`ifdef SQRT_TIMEOUT_EN
  logic              timeout;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  int start_base;

  sqrt_sumsq_feeder #(
    .IN_W        (8),
    .OUT_W       (16),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .sq_start (sq_start),
    .sq_in    (sq_in),
    .sq_done  (sq_done),
    .busy     (busy),
    .sat      (sat)
`ifdef SQRT_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count start pulses as the DUT presents them at each rising edge
  always @(posedge clk) begin
    if (sq_start === 1'b1) start_cnt = start_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Full transaction: present a pair, follow it to ISSUE, let the root take
  // a few cycles, then answer with sq_done.
  task automatic run_pair(input string tag, input logic signed [7:0] x,
                          input logic signed [7:0] y, input int exp_in,
                          input logic exp_sat);
    start_base = start_cnt;
    in_valid = 1'b1; in_x = x; in_y = y;
    step();                                   // accept edge -> SQX
    in_valid = 1'b0;
    chk({tag, "_ready_low"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_sat_clr"}, 32'(sat), 32'd0);
    step();                                   // SQY
    chk({tag, "_no_early_start"}, 32'(sq_start), 32'd0);
    step();                                   // ISSUE
    chk({tag, "_start"}, 32'(sq_start), 32'd1);
    chk({tag, "_sq_in"}, 32'(sq_in), 32'(exp_in));
    chk({tag, "_sat"}, 32'(sat), 32'(exp_sat));
    step();                                   // WAIT
    chk({tag, "_start_drop"}, 32'(sq_start), 32'd0);
    step(); step();
    chk({tag, "_wait_ready"}, 32'(in_ready), 32'd0);
    sq_done = 1'b1;
    step();                                   // back to IDLE
    sq_done = 1'b0;
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_hold"}, 32'(sq_in), 32'(exp_in));
    chk({tag, "_one_pulse"}, 32'(start_cnt - start_base), 32'd1);
    $display("pair %s x=%0d y=%0d sq_in=%0d sat=%0d", tag, x, y, sq_in, sat);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; sq_done = 1'b0;
    #3;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(sq_start), 32'd0);
    chk("rst_sq_in", 32'(sq_in), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    step(); step();
    rst = 1'b1;
    step();

    // Nominal, saturation, single corner and zero
    run_pair("nom_3_4", 8'sd3, 8'sd4, 25, 1'b0);
    run_pair("sat_m128", -8'sd128, -8'sd128, 32767, 1'b1);
    run_pair("corner_m128_0", -8'sd128, 8'sd0, 16384, 1'b0);
    run_pair("zero", 8'sd0, 8'sd0, 0, 1'b0);

    // Backpressure: second pair waits while the first is in WAIT
    start_base = start_cnt;
    in_valid = 1'b1; in_x = 8'sd3; in_y = 8'sd4;
    step();                                   // SQX
    in_x = 8'sd5; in_y = 12;
    step(); step(); step();                   // SQY, ISSUE, WAIT
    chk("bp_wait_ready", 32'(in_ready), 32'd0);
    step(); step();
    chk("bp_still_busy", 32'(busy), 32'd1);
    chk("bp_first_in", 32'(sq_in), 32'd25);
    chk("bp_one_start", 32'(start_cnt - start_base), 32'd1);
    sq_done = 1'b1;
    step();                                   // IDLE, in_valid still high
    sq_done = 1'b0;
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    step();                                   // accept second pair
    in_valid = 1'b0;
    chk("bp_accepted", 32'(busy), 32'd1);
    step(); step();                           // SQY, ISSUE
    chk("bp_second_start", 32'(sq_start), 32'd1);
    chk("bp_second_in", 32'(sq_in), 32'd169);
    step();
    sq_done = 1'b1;
    step();
    sq_done = 1'b0;
    chk("bp_two_starts", 32'(start_cnt - start_base), 32'd2);
    $display("backpressure 3/4 then 5/12 sq_in=%0d starts=%0d", sq_in, start_cnt - start_base);

    // Spurious done in SQX is ignored; reset mid-WAIT aborts
    start_base = start_cnt;
    in_valid = 1'b1; in_x = -8'sd128; in_y = -8'sd128;
    step();                                   // SQX
    in_valid = 1'b0;
    sq_done = 1'b1;
    step();                                   // SQY (done ignored)
    sq_done = 1'b0;
    chk("spur_busy", 32'(busy), 32'd1);
    step();                                   // ISSUE
    chk("spur_start", 32'(sq_start), 32'd1);
    chk("spur_sq_in", 32'(sq_in), 32'd32767);
    step(); step();                           // WAIT
    chk("spur_wait_sat", 32'(sat), 32'd1);
    #2;
    rst = 1'b0;                               // mid-cycle, no edge
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_sq_in", 32'(sq_in), 32'd0);
    chk("arst_sat", 32'(sat), 32'd0);
    chk("arst_start", 32'(sq_start), 32'd0);
    step(); step();
    rst = 1'b1;
    step(); step(); step(); step();
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_starts", 32'(start_cnt - start_base), 32'd1);
    $display("spurious done + reset: starts=%0d ready=%0d", start_cnt - start_base, in_ready);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
